four_one_rr_mux: RTL and testbench

FOUR_ONE_RR_MUX -- requirements
Module: four_one_rr_mux

---
 rtl/four_one_rr_mux.sv | 77 +++++++
 tb/tb_four_one_rr_mux.sv | 138 +++++++++++++
 2 files changed

// File: rtl/four_one_rr_mux.sv
// Four-channel round-robin arbiter feeding a single registered output stage.
// Grants rotate starting one past the last winner; the output register drains and refills in one cycle.
module four_one_rr_mux #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         i_valid,
  input  logic [4*WIDTH-1:0] i_data,
  output logic [3:0]         i_ready,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic [1:0]         o_sel,
  input  logic               o_ready
);

  logic [1:0]       r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;

  logic             w_load;
  logic             w_anyValid;
  logic [1:0]       w_grantIdx;
  logic [1:0]       w_scanIdx;
  logic             w_transfer;
  logic [WIDTH-1:0] w_grantData;

  assign w_load = !r_valid || o_ready;

  // Scan from the farthest offset back to the pointer so the closest valid channel wins.
  always_comb begin
    w_anyValid = 1'b0;
    w_grantIdx = r_ptr;
    w_scanIdx  = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_scanIdx = r_ptr + 2'(i);
      if (i_valid[w_scanIdx]) begin
        w_anyValid = 1'b1;
        w_grantIdx = w_scanIdx;
      end
    end
  end

  assign w_transfer  = rst_n && w_load && w_anyValid;
  assign w_grantData = i_data[w_grantIdx*WIDTH +: WIDTH];

  always_comb begin
    i_ready = 4'b0000;
    if (w_transfer) begin
      i_ready[w_grantIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'b00;
      r_ptr   <= 2'b00;
    end else if (w_load) begin
      if (w_anyValid) begin
        r_valid <= 1'b1;
        r_data  <= w_grantData;
        r_sel   <= w_grantIdx;
        r_ptr   <= w_grantIdx + 2'd1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sel   = r_sel;

endmodule

// File: tb/tb_four_one_rr_mux.sv
// Directed bench for four_one_rr_mux: a vector table walking arbitration cases,
// plus hand sequences for power-on and mid-operation reset.
module tb_four_one_rr_mux;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [3:0]         i_valid;
  logic [4*WIDTH-1:0] i_data;
  logic [3:0]         i_ready;
  logic               o_valid;
  logic [WIDTH-1:0]   o_data;
  logic [1:0]         o_sel;
  logic               o_ready;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        oReady;
    logic [3:0]  expReady;
    logic        expOValid;
    logic [7:0]  expOData;
    logic [1:0]  expOSel;
  } vector_t;

  vector_t vecs[24];

  four_one_rr_mux #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .o_ready (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive at the falling edge, check the combinational ready, then the registered outputs after the rising edge.
  task automatic applyStimulus(input int idx, input vector_t v);
    @(negedge clk);
    i_valid = v.valid;
    i_data  = v.data;
    o_ready = v.oReady;
    #1;
    checkOutput($sformatf("v%0d i_ready", idx), 32'(i_ready), 32'(v.expReady));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d o_valid", idx), 32'(o_valid), 32'(v.expOValid));
    checkOutput($sformatf("v%0d o_data", idx), 32'(o_data), 32'(v.expOData));
    checkOutput($sformatf("v%0d o_sel", idx), 32'(o_sel), 32'(v.expOSel));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Channel data 8'h10..8'h13 unless a vector overrides it.
    vecs[0]  = '{4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[1]  = '{4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[2]  = '{4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[3]  = '{4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[4]  = '{4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[5]  = '{4'b0100, 32'h13A51110, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[6]  = '{4'b1000, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[7]  = '{4'b1001, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[8]  = '{4'b1001, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[9]  = '{4'b0000, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3};
    vecs[10] = '{4'b0010, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[11] = '{4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[12] = '{4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[13] = '{4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[14] = '{4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[15] = '{4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[16] = '{4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[17] = '{4'b0011, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[18] = '{4'b0000, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    vecs[19] = '{4'b0000, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};
    vecs[20] = '{4'b0110, 32'h13121110, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[21] = '{4'b0110, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[22] = '{4'b0011, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[23] = '{4'b0010, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};

    // Power-on reset with every channel requesting.
    rst_n   = 1'b0;
    i_valid = 4'b1111;
    i_data  = 32'h13121110;
    o_ready = 1'b1;
    #3;
    checkOutput("reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("reset o_data", 32'(o_data), 32'd0);
    checkOutput("reset o_sel", 32'(o_sel), 32'd0);
    checkOutput("reset i_ready", 32'(i_ready), 32'd0);
    @(negedge clk);
    i_valid = 4'b0000;
    rst_n   = 1'b1;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Stall with a word held, then pulse reset between clock edges.
    applyStimulus(100, '{4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset o_valid", 32'(o_valid), 32'd0);
    checkOutput("midreset o_data", 32'(o_data), 32'd0);
    checkOutput("midreset o_sel", 32'(o_sel), 32'd0);
    checkOutput("midreset i_ready", 32'(i_ready), 32'd0);
    @(negedge clk);
    i_valid = 4'b0000;
    rst_n   = 1'b1;
    applyStimulus(101, '{4'b1010, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1});
    applyStimulus(102, '{4'b1010, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
